// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decode results for EX, with stall, flush,
// valid tracking and saturating bubble/stall/flush event counters.
module id_ex_pipe_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [1:0]        ALUOp_i,
    input  logic              ALUSrc_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic              Branch_i,
    input  logic [XLEN-1:0]   RS1data_i,
    input  logic [XLEN-1:0]   RS2data_i,
    input  logic [XLEN-1:0]   Imm_i,
    input  logic [XLEN-1:0]   PC_i,
    input  logic [9:0]        funct_i,
    input  logic [4:0]        RS1addr_i,
    input  logic [4:0]        RS2addr_i,
    input  logic [4:0]        RDaddr_i,
    output logic              valid_o,
    output logic [1:0]        ALUOp_o,
    output logic              ALUSrc_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              Branch_o,
    output logic [XLEN-1:0]   RS1data_o,
    output logic [XLEN-1:0]   RS2data_o,
    output logic [XLEN-1:0]   Imm_o,
    output logic [XLEN-1:0]   PC_o,
    output logic [9:0]        funct_o,
    output logic [4:0]        RS1addr_o,
    output logic [4:0]        RS2addr_o,
    output logic [4:0]        RDaddr_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            // Reset and flush both leave EX holding an all-zero bubble.
            valid_o    <= 1'b0;
            ALUOp_o    <= 2'b00;
            ALUSrc_o   <= 1'b0;
            RegWrite_o <= 1'b0;
            MemtoReg_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            Branch_o   <= 1'b0;
            RS1data_o  <= '0;
            RS2data_o  <= '0;
            Imm_o      <= '0;
            PC_o       <= '0;
            funct_o    <= '0;
            RS1addr_o  <= '0;
            RS2addr_o  <= '0;
            RDaddr_o   <= '0;
            if (rst_i) begin
                bubble_cnt_o <= '0;
                stall_cnt_o  <= '0;
                flush_cnt_o  <= '0;
            end else begin
                bubble_cnt_o <= sat_inc(bubble_cnt_o);
                flush_cnt_o  <= sat_inc(flush_cnt_o);
            end
        end else if (stall_i) begin
            stall_cnt_o <= sat_inc(stall_cnt_o);
        end else begin
            // A NoOp from decode must never carry live control bits into EX.
            valid_o    <= valid_i;
            ALUOp_o    <= valid_i ? ALUOp_i : 2'b00;
            ALUSrc_o   <= ALUSrc_i   & valid_i;
            RegWrite_o <= RegWrite_i & valid_i;
            MemtoReg_o <= MemtoReg_i & valid_i;
            MemRead_o  <= MemRead_i  & valid_i;
            MemWrite_o <= MemWrite_i & valid_i;
            Branch_o   <= Branch_i   & valid_i;
            RS1data_o  <= RS1data_i;
            RS2data_o  <= RS2data_i;
            Imm_o      <= Imm_i;
            PC_o       <= PC_i;
            funct_o    <= funct_i;
            RS1addr_o  <= RS1addr_i;
            RS2addr_o  <= RS2addr_i;
            RDaddr_o   <= RDaddr_i;
            if (!valid_i) begin
                bubble_cnt_o <= sat_inc(bubble_cnt_o);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus randomized
// traffic against a behavioural model; a CNT_W=2 instance covers saturation.
module tb_id_ex_pipe_reg;

    localparam int BW = 162;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, stall_i, flush_i, valid_i;
    logic [1:0]  ALUOp_i;
    logic        ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i;
    logic [31:0] RS1data_i, RS2data_i, Imm_i, PC_i;
    logic [9:0]  funct_i;
    logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;

    logic        valid_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o;
    logic [1:0]  ALUOp_o;
    logic [31:0] RS1data_o, RS2data_o, Imm_o, PC_o;
    logic [9:0]  funct_o;
    logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
    logic [15:0] bubble_cnt_o, stall_cnt_o, flush_cnt_o;

    logic        s_valid, s_alusrc, s_regwrite, s_memtoreg, s_memread, s_memwrite, s_branch;
    logic [1:0]  s_aluop;
    logic [31:0] s_rs1data, s_rs2data, s_imm, s_pc;
    logic [9:0]  s_funct;
    logic [4:0]  s_rs1addr, s_rs2addr, s_rdaddr;
    logic [1:0]  s_bubble_cnt, s_stall_cnt, s_flush_cnt;

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .Branch_i(Branch_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .PC_i(PC_i),
        .funct_i(funct_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .valid_o(valid_o), .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
        .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .Branch_o(Branch_o),
        .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .PC_o(PC_o),
        .funct_o(funct_o), .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
        .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .Branch_i(Branch_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .PC_i(PC_i),
        .funct_i(funct_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .valid_o(s_valid), .ALUOp_o(s_aluop), .ALUSrc_o(s_alusrc), .RegWrite_o(s_regwrite),
        .MemtoReg_o(s_memtoreg), .MemRead_o(s_memread), .MemWrite_o(s_memwrite), .Branch_o(s_branch),
        .RS1data_o(s_rs1data), .RS2data_o(s_rs2data), .Imm_o(s_imm), .PC_o(s_pc),
        .funct_o(s_funct), .RS1addr_o(s_rs1addr), .RS2addr_o(s_rs2addr), .RDaddr_o(s_rdaddr),
        .bubble_cnt_o(s_bubble_cnt), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    // Same field order for inputs, DUT outputs and the model: 8 control bits on top, valid at bit 0.
    logic [BW-1:0] in_bus, dut_bus, sat_bus;
    assign in_bus  = {ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, Branch_i,
                      RS1data_i, RS2data_i, Imm_i, PC_i, funct_i, RS1addr_i, RS2addr_i, RDaddr_i, valid_i};
    assign dut_bus = {ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, Branch_o,
                      RS1data_o, RS2data_o, Imm_o, PC_o, funct_o, RS1addr_o, RS2addr_o, RDaddr_o, valid_o};
    assign sat_bus = {s_aluop, s_alusrc, s_regwrite, s_memtoreg, s_memread, s_memwrite, s_branch,
                      s_rs1data, s_rs2data, s_imm, s_pc, s_funct, s_rs1addr, s_rs2addr, s_rdaddr, s_valid};

    logic [BW-1:0] exp_bus;
    int exp_bubble, exp_stall, exp_flush;
    int exp_bubble2, exp_stall2, exp_flush2;
    int errors = 0;
    int checks = 0;

    function automatic int bump(input int c, input int max);
        return (c < max) ? c + 1 : c;
    endfunction

    task automatic model_step();
        if (rst_i) begin
            exp_bus = '0;
            exp_bubble = 0; exp_stall = 0; exp_flush = 0;
            exp_bubble2 = 0; exp_stall2 = 0; exp_flush2 = 0;
        end else if (flush_i) begin
            exp_bus = '0;
            exp_flush  = bump(exp_flush, 65535);  exp_bubble  = bump(exp_bubble, 65535);
            exp_flush2 = bump(exp_flush2, 3);     exp_bubble2 = bump(exp_bubble2, 3);
        end else if (stall_i) begin
            exp_stall  = bump(exp_stall, 65535);
            exp_stall2 = bump(exp_stall2, 3);
        end else begin
            exp_bus = in_bus;
            if (!valid_i) begin
                exp_bus[BW-1 -: 8] = 8'h00;
                exp_bubble  = bump(exp_bubble, 65535);
                exp_bubble2 = bump(exp_bubble2, 3);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        rst_i = 0; stall_i = 0; flush_i = 0; valid_i = 0;
        ALUOp_i = 0; ALUSrc_i = 0; RegWrite_i = 0; MemtoReg_i = 0;
        MemRead_i = 0; MemWrite_i = 0; Branch_i = 0;
        RS1data_i = 0; RS2data_i = 0; Imm_i = 0; PC_i = 0;
        funct_i = 0; RS1addr_i = 0; RS2addr_i = 0; RDaddr_i = 0;
    endtask

    task automatic random_payload();
        ALUOp_i = 2'($urandom); ALUSrc_i = 1'($urandom); RegWrite_i = 1'($urandom);
        MemtoReg_i = 1'($urandom); MemRead_i = 1'($urandom); MemWrite_i = 1'($urandom);
        Branch_i = 1'($urandom);
        RS1data_i = $urandom; RS2data_i = $urandom; Imm_i = $urandom; PC_i = $urandom;
        funct_i = 10'($urandom); RS1addr_i = 5'($urandom); RS2addr_i = 5'($urandom);
        RDaddr_i = 5'($urandom);
    endtask

    task automatic test_reset();
        clear_inputs();
        random_payload();
        ALUOp_i = 2'b11; RegWrite_i = 1; MemWrite_i = 1; RS1data_i = 32'hFFFF_FFFF;
        valid_i = 1; stall_i = 1; flush_i = 1; rst_i = 1;
        tick();
        checks++;
        if (dut_bus !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", dut_bus);
        end
        checks++;
        if ({bubble_cnt_o, stall_cnt_o, flush_cnt_o} !== 48'h0) begin
            errors++; $display("FAIL reset_counters got=%h/%h/%h exp=0/0/0", bubble_cnt_o, stall_cnt_o, flush_cnt_o);
        end
        tick();
        checks++;
        if (dut_bus !== exp_bus || sat_bus !== exp_bus) begin
            errors++; $display("FAIL reset_hold got=%h exp=%h", dut_bus, exp_bus);
        end
        rst_i = 0;
    endtask

    task automatic test_normal_load();
        clear_inputs();
        ALUOp_i = 2'b10; RegWrite_i = 1; RS1data_i = 32'h0000_0005; RDaddr_i = 5'd3; valid_i = 1;
        tick();
        checks++;
        if (ALUOp_o !== 2'b10 || RegWrite_o !== 1'b1 || RS1data_o !== 32'd5 || RDaddr_o !== 5'd3 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rtype_load got aluop=%b rw=%b rs1=%h rd=%0d v=%b exp aluop=10 rw=1 rs1=5 rd=3 v=1",
                     ALUOp_o, RegWrite_o, RS1data_o, RDaddr_o, valid_o);
        end
        checks++;
        if (dut_bus !== exp_bus) begin
            errors++; $display("FAIL rtype_full got=%h exp=%h", dut_bus, exp_bus);
        end
    endtask

    task automatic test_stall_hold();
        logic [BW-1:0] held;
        held = dut_bus;
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            random_payload();
            valid_i = 1'($urandom);
            tick();
            checks++;
            if (dut_bus !== held || dut_bus !== exp_bus) begin
                errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, dut_bus, held);
            end
        end
        checks++;
        if (stall_cnt_o !== 16'd3 || bubble_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
            errors++; $display("FAIL stall_counters got b=%0d s=%0d f=%0d exp b=0 s=3 f=0",
                               bubble_cnt_o, stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_flush_over_stall();
        random_payload();
        MemWrite_i = 1; ALUSrc_i = 1; RegWrite_i = 0; valid_i = 1;
        stall_i = 1; flush_i = 1;
        tick();
        checks++;
        if (MemWrite_o !== 1'b0 || valid_o !== 1'b0 || dut_bus !== '0) begin
            errors++; $display("FAIL flush_bubble got=%h exp=0", dut_bus);
        end
        checks++;
        if (flush_cnt_o !== 16'd1 || bubble_cnt_o !== 16'd1 || stall_cnt_o !== 16'd3) begin
            errors++; $display("FAIL flush_counters got b=%0d s=%0d f=%0d exp b=1 s=3 f=1",
                               bubble_cnt_o, stall_cnt_o, flush_cnt_o);
        end
        stall_i = 0; flush_i = 0;
    endtask

    task automatic test_noop_bubble();
        random_payload();
        RegWrite_i = 1; MemRead_i = 1; valid_i = 0;
        tick();
        checks++;
        if (RegWrite_o !== 1'b0 || MemRead_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++; $display("FAIL noop_ctrl got rw=%b mr=%b v=%b exp 0 0 0", RegWrite_o, MemRead_o, valid_o);
        end
        checks++;
        if (bubble_cnt_o !== 16'd2 || dut_bus !== exp_bus) begin
            errors++; $display("FAIL noop_data got b=%0d bus=%h exp b=2 bus=%h", bubble_cnt_o, dut_bus, exp_bus);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] seq [6];
        seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        clear_inputs();
        rst_i = 1;
        tick();
        rst_i = 0; stall_i = 1;
        for (int i = 0; i < 6; i++) begin
            random_payload();
            tick();
            checks++;
            if (s_stall_cnt !== seq[i] || int'(s_stall_cnt) !== exp_stall2) begin
                errors++; $display("FAIL sat_stall[%0d] got=%0d exp=%0d", i, s_stall_cnt, seq[i]);
            end
        end
        checks++;
        if (stall_cnt_o !== 16'd6) begin
            errors++; $display("FAIL wide_stall got=%0d exp=6", stall_cnt_o);
        end
        rst_i = 1;
        tick();
        checks++;
        if (s_stall_cnt !== 2'd0 || stall_cnt_o !== 16'd0) begin
            errors++; $display("FAIL sat_reset got=%0d/%0d exp=0/0", s_stall_cnt, stall_cnt_o);
        end
        rst_i = 0; stall_i = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            random_payload();
            rst_i   = ($urandom_range(0, 39) == 0);
            flush_i = ($urandom_range(0, 5) == 0);
            stall_i = ($urandom_range(0, 3) == 0);
            valid_i = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (dut_bus !== exp_bus || sat_bus !== exp_bus) begin
                errors++; $display("FAIL rand_bus[%0d] got=%h exp=%h", i, dut_bus, exp_bus);
            end
            checks++;
            if (int'(bubble_cnt_o) !== exp_bubble || int'(stall_cnt_o) !== exp_stall || int'(flush_cnt_o) !== exp_flush) begin
                errors++; $display("FAIL rand_cnt[%0d] got b=%0d s=%0d f=%0d exp b=%0d s=%0d f=%0d",
                                   i, bubble_cnt_o, stall_cnt_o, flush_cnt_o, exp_bubble, exp_stall, exp_flush);
            end
            checks++;
            if (int'(s_bubble_cnt) !== exp_bubble2 || int'(s_stall_cnt) !== exp_stall2 || int'(s_flush_cnt) !== exp_flush2) begin
                errors++; $display("FAIL rand_satcnt[%0d] got b=%0d s=%0d f=%0d exp b=%0d s=%0d f=%0d",
                                   i, s_bubble_cnt, s_stall_cnt, s_flush_cnt, exp_bubble2, exp_stall2, exp_flush2);
            end
            checks++;
            if (!valid_o && (RegWrite_o || MemWrite_o || MemRead_o || Branch_o)) begin
                errors++; $display("FAIL rand_invariant[%0d] got ctrl=%h exp ctrl=0 when invalid", i, dut_bus[BW-1 -: 8]);
            end
        end
    endtask

    initial begin
        exp_bus = '0;
        exp_bubble = 0; exp_stall = 0; exp_flush = 0;
        exp_bubble2 = 0; exp_stall2 = 0; exp_flush2 = 0;
        clear_inputs();
        test_reset();
        test_normal_load();
        test_stall_hold();
        test_flush_over_stall();
        test_noop_bubble();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
